// File: rtl/tbird_pkg.sv
// tbird_pkg: lamp states, pattern constants, direction codes and decode helpers.
// The HZ state and hazard pattern acceptance exist only when TBIRD_HAZARD_EN is defined.
package tbird_pkg;

    typedef enum logic [3:0] {
        OFF, L1, L2, L3, R1, R2, R3, UNSYNC
`ifdef TBIRD_HAZARD_EN
        , HZ
`endif
    } lamp_state_t;

    localparam logic [5:0] PAT_OFF = 6'b000000;
    localparam logic [5:0] PAT_L1  = 6'b001000;
    localparam logic [5:0] PAT_L2  = 6'b011000;
    localparam logic [5:0] PAT_L3  = 6'b111000;
    localparam logic [5:0] PAT_R1  = 6'b000100;
    localparam logic [5:0] PAT_R2  = 6'b000110;
    localparam logic [5:0] PAT_R3  = 6'b000111;
    localparam logic [5:0] PAT_HZ  = 6'b111111;

    localparam logic [1:0] DIR_IDLE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_OTHER = 2'b11;

    // UNSYNC doubles as the "illegal pattern" marker
    function automatic lamp_state_t decode_pat(input logic [5:0] p);
        case (p)
            PAT_OFF: return OFF;
            PAT_L1:  return L1;
            PAT_L2:  return L2;
            PAT_L3:  return L3;
            PAT_R1:  return R1;
            PAT_R2:  return R2;
            PAT_R3:  return R3;
`ifdef TBIRD_HAZARD_EN
            PAT_HZ:  return HZ;
`endif
            default: return UNSYNC;
        endcase
    endfunction

    function automatic lamp_state_t succ(input lamp_state_t s);
        case (s)
            L1:      return L2;
            L2:      return L3;
            R1:      return R2;
            R2:      return R3;
            L3, R3:  return OFF;
`ifdef TBIRD_HAZARD_EN
            HZ:      return OFF;
`endif
            default: return UNSYNC;
        endcase
    endfunction

    function automatic logic is_start(input lamp_state_t s);
`ifdef TBIRD_HAZARD_EN
        return s inside {OFF, L1, R1, HZ};
`else
        return s inside {OFF, L1, R1};
`endif
    endfunction

    function automatic logic [1:0] dir_of(input lamp_state_t s);
        return s == OFF ? DIR_IDLE
             : s inside {L1, L2, L3} ? DIR_LEFT
             : s inside {R1, R2, R3} ? DIR_RIGHT : DIR_OTHER;
    endfunction

    function automatic logic [1:0] phase_of(input lamp_state_t s);
        return s inside {L1, R1} ? 2'd1
             : s inside {L2, R2} ? 2'd2
             : (s == OFF || s == UNSYNC) ? 2'd0 : 2'd3;
    endfunction

endpackage

// File: rtl/tbird_lamp_monitor_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/tbird_lamp_monitor.sv
// tbird_lamp_monitor: checks Thunderbird tail-lamp pattern sequences and counts completed ones.
// Define TBIRD_HAZARD_EN to accept the all-lamps hazard flash and expose haz_count.
module tbird_lamp_monitor
    import tbird_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LC,
    input  logic             LB,
    input  logic             LA,
    input  logic             RA,
    input  logic             RB,
    input  logic             RC,
    output logic [1:0]       dir,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count
`ifdef TBIRD_HAZARD_EN
    ,
    output logic [CNT_W-1:0] haz_count
`endif
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;

    lamp_state_t   state_q, state_d, pat_st;
    logic [HW-1:0] hold_q, hold_d;
    logic          holding, step_ok, err_d, left_inc, right_inc;
`ifdef TBIRD_HAZARD_EN
    logic          haz_inc;
`endif

    always_comb begin
        pat_st    = decode_pat({LC, LB, LA, RA, RB, RC});
        holding   = pat_st == state_q && state_q != OFF && state_q != UNSYNC;
        step_ok   = state_q == OFF ? is_start(pat_st) : pat_st == succ(state_q);
        // UNSYNC is silent until OFF brings it back in step
        err_d     = state_q != UNSYNC && (holding ? int'(hold_q) >= MAX_HOLD - 1 : !step_ok);
        state_d   = state_q == UNSYNC ? (pat_st == OFF ? OFF : UNSYNC)
                  : !err_d ? pat_st
                  : pat_st inside {OFF, L1, R1} ? pat_st : UNSYNC;
        hold_d    = holding && !err_d ? hold_q + 1'b1 : '0;
        left_inc  = !err_d && state_q == L3 && pat_st == OFF;
        right_inc = !err_d && state_q == R3 && pat_st == OFF;
`ifdef TBIRD_HAZARD_EN
        haz_inc   = !err_d && state_q == HZ && pat_st == OFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            hold_q     <= '0;
            dir        <= DIR_IDLE;
            phase      <= 2'd0;
            seq_done   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            dir        <= dir_of(state_d);
            phase      <= phase_of(state_d);
`ifdef TBIRD_HAZARD_EN
            seq_done   <= left_inc | right_inc | haz_inc;
`else
            seq_done   <= left_inc | right_inc;
`endif
            err        <= err_d;
            err_sticky <= err_sticky | err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_left  (.clk(clk), .rst(rst), .inc(left_inc),  .q(left_count));
    sat_counter #(.W(CNT_W)) u_right (.clk(clk), .rst(rst), .inc(right_inc), .q(right_count));
`ifdef TBIRD_HAZARD_EN
    sat_counter #(.W(CNT_W)) u_haz   (.clk(clk), .rst(rst), .inc(haz_inc),   .q(haz_count));
`endif
endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// tb_tbird_lamp_monitor: directed vector table, corner sequences and random stimulus against a side/phase model.
module tb_tbird_lamp_monitor;
    localparam logic [5:0] OF = 6'b000000, A1 = 6'b001000, A2 = 6'b011000, A3 = 6'b111000;
    localparam logic [5:0] B1 = 6'b000100, B2 = 6'b000110, B3 = 6'b000111, HZP = 6'b111111;
`ifdef TBIRD_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pat = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    logic [1:0] dir0, dir1, dir2, ph0, ph1, ph2;
    logic       sd0, sd1, sd2, er0, er1, er2, st0, st1, st2;
    logic [7:0] lc0, lc1, rc0, rc1, hz0, hz1;
    logic [1:0] lc2, rc2, hz2;
`ifndef TBIRD_HAZARD_EN
    assign hz0 = '0;
    assign hz1 = '0;
    assign hz2 = '0;
`endif

    tbird_lamp_monitor u0 (
        .clk(clk), .rst(rst), .LC(pat[5]), .LB(pat[4]), .LA(pat[3]), .RA(pat[2]), .RB(pat[1]), .RC(pat[0]),
        .dir(dir0), .phase(ph0), .seq_done(sd0), .err(er0), .err_sticky(st0), .left_count(lc0), .right_count(rc0)
`ifdef TBIRD_HAZARD_EN
        , .haz_count(hz0)
`endif
    );
    tbird_lamp_monitor #(.MAX_HOLD(2)) u1 (
        .clk(clk), .rst(rst), .LC(pat[5]), .LB(pat[4]), .LA(pat[3]), .RA(pat[2]), .RB(pat[1]), .RC(pat[0]),
        .dir(dir1), .phase(ph1), .seq_done(sd1), .err(er1), .err_sticky(st1), .left_count(lc1), .right_count(rc1)
`ifdef TBIRD_HAZARD_EN
        , .haz_count(hz1)
`endif
    );
    tbird_lamp_monitor #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .LC(pat[5]), .LB(pat[4]), .LA(pat[3]), .RA(pat[2]), .RB(pat[1]), .RC(pat[0]),
        .dir(dir2), .phase(ph2), .seq_done(sd2), .err(er2), .err_sticky(st2), .left_count(lc2), .right_count(rc2)
`ifdef TBIRD_HAZARD_EN
        , .haz_count(hz2)
`endif
    );

    typedef struct {
        logic [1:0] dir;
        logic [1:0] ph;
        logic       sd;
        logic       er;
        logic       st;
        logic [7:0] lc;
        logic [7:0] rc;
        logic [7:0] hz;
    } obs_t;
    obs_t obs[3];

    always_comb begin
        obs[0] = '{dir0, ph0, sd0, er0, st0, lc0, rc0, hz0};
        obs[1] = '{dir1, ph1, sd1, er1, st1, lc1, rc1, hz1};
        obs[2] = '{dir2, ph2, sd2, er2, st2, {6'd0, lc2}, {6'd0, rc2}, {6'd0, hz2}};
    end

    // Model: each config tracks active side (0 none, 1 left, 2 right, 3 hazard) and lit count
    int mh[3]   = '{1, 2, 1};
    int cmax[3] = '{255, 255, 3};
    int m_side[3], m_n[3], m_hold[3], m_lc[3], m_rc[3], m_hz[3];
    bit m_uns[3], m_done[3], m_err[3], m_sticky[3];

    function automatic void decode(input logic [5:0] p, output int s, output int n, output bit ok);
        logic [2:0] l, r;
        l  = p[5:3];
        r  = p[2:0];
        ok = (l inside {3'b000, 3'b001, 3'b011, 3'b111}) && (r inside {3'b000, 3'b100, 3'b110, 3'b111});
        if (l == 0 && r == 0) begin s = 0; n = 0; end
        else if (r == 0) begin s = 1; n = $countones(l); end
        else if (l == 0) begin s = 2; n = $countones(r); end
        else begin s = 3; n = 3; ok = HAZ && l == 3'b111 && r == 3'b111; end
    endfunction

    function automatic logic [5:0] encode(input int s, input int n);
        logic [2:0] t;
        t = 3'((1 << n) - 1);
        return s == 1 ? {t, 3'b000} : s == 2 ? {3'b000, {t[0], t[1], t[2]}} : s == 3 ? HZP : OF;
    endfunction

    function automatic int sat(input int v, input int mx);
        return v < mx ? v + 1 : mx;
    endfunction

    task automatic model_step(input bit r, input logic [5:0] p);
        int s, n;
        bit ok, same, e, go;
        decode(p, s, n, ok);
        for (int k = 0; k < 3; k++) begin
            e = 0; go = 0; m_done[k] = 0;
            if (r) begin
                m_side[k] = 0; m_n[k] = 0; m_hold[k] = 0; m_uns[k] = 0;
                m_sticky[k] = 0; m_lc[k] = 0; m_rc[k] = 0; m_hz[k] = 0;
            end else if (m_uns[k]) begin
                if (ok && s == 0) begin m_uns[k] = 0; m_side[k] = 0; m_n[k] = 0; end
            end else begin
                same = ok && s == m_side[k] && n == m_n[k];
                if (same) begin
                    if (s != 0) begin
                        if (m_hold[k] + 1 > mh[k] - 1) e = 1;
                        else m_hold[k]++;
                    end
                end else if (ok && m_side[k] == 0 && (n == 1 || s == 3)) go = 1;
                else if (ok && (m_side[k] == 1 || m_side[k] == 2) && s == m_side[k] && n == m_n[k] + 1) go = 1;
                else if (ok && s == 0 && m_n[k] == 3) begin
                    go = 1;
                    m_done[k] = 1;
                    if (m_side[k] == 1) m_lc[k] = sat(m_lc[k], cmax[k]);
                    else if (m_side[k] == 2) m_rc[k] = sat(m_rc[k], cmax[k]);
                    else m_hz[k] = sat(m_hz[k], cmax[k]);
                end else e = 1;
                if (go) begin m_side[k] = s; m_n[k] = n; m_hold[k] = 0; end
                if (e) begin
                    m_hold[k] = 0;
                    if (ok && (s == 0 || n == 1)) begin m_side[k] = s; m_n[k] = n; end
                    else m_uns[k] = 1;
                end
            end
            m_err[k] = e;
            m_sticky[k] = m_sticky[k] | e;
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            chk("m_dir", k, 32'(obs[k].dir), m_uns[k] ? 3 : m_side[k]);
            chk("m_phase", k, 32'(obs[k].ph), m_uns[k] ? 0 : m_n[k]);
            chk("m_seq_done", k, 32'(obs[k].sd), 32'(m_done[k]));
            chk("m_err", k, 32'(obs[k].er), 32'(m_err[k]));
            chk("m_err_sticky", k, 32'(obs[k].st), 32'(m_sticky[k]));
            chk("m_left_count", k, 32'(obs[k].lc), m_lc[k]);
            chk("m_right_count", k, 32'(obs[k].rc), m_rc[k]);
`ifdef TBIRD_HAZARD_EN
            chk("m_haz_count", k, 32'(obs[k].hz), m_hz[k]);
`endif
        end
    endtask

    task automatic step(input bit r, input logic [5:0] p);
        rst = r;
        pat = p;
        @(posedge clk);
        #1;
        model_step(r, p);
        cmp_model();
    endtask

    task automatic left_seq();
        step(0, A1); step(0, A2); step(0, A3); step(0, OF);
    endtask

    typedef struct {
        bit         r;
        logic [5:0] p;
        logic [1:0] d;
        logic [1:0] ph;
        bit         sd;
        bit         er;
        bit         st;
        logic [7:0] lc;
        logic [7:0] rc;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input bit r, input logic [5:0] p, input int d, input int ph,
                                input bit sd, input bit er, input bit st, input int lc, input int rc);
        vec_t v;
        v = '{r, p, 2'(d), 2'(ph), sd, er, st, 8'(lc), 8'(rc)};
        return v;
    endfunction

    initial begin
        vt.push_back(mk(1, OF, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, OF, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A3, 1, 3, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, OF, 0, 0, 1, 0, 0, 1, 0));
        for (int i = 1; i <= 3; i++) begin
            vt.push_back(mk(0, B1, 2, 1, 0, 0, 0, 1, i - 1));
            vt.push_back(mk(0, B2, 2, 2, 0, 0, 0, 1, i - 1));
            vt.push_back(mk(0, B3, 2, 3, 0, 0, 0, 1, i - 1));
            vt.push_back(mk(0, OF, 0, 0, 1, 0, 0, 1, i));
        end
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 0, 1, 3));
        vt.push_back(mk(0, A3, 3, 0, 0, 1, 1, 1, 3));
        vt.push_back(mk(0, 6'b011100, 3, 0, 0, 0, 1, 1, 3));
        vt.push_back(mk(0, OF, 0, 0, 0, 0, 1, 1, 3));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 1, 1, 3));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 1, 1, 3));
        vt.push_back(mk(1, A3, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, OF, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, A3, 1, 3, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, OF, 0, 0, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, A3, 1, 3, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, OF, 0, 0, 1, 0, 1, 2, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, OF, 0, 0, 0, 1, 1, 2, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, A1, 1, 1, 0, 1, 1, 2, 0));
        vt.push_back(mk(0, A2, 1, 2, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, A3, 1, 3, 0, 0, 1, 2, 0));
        vt.push_back(mk(0, OF, 0, 0, 1, 0, 1, 3, 0));
        vt.push_back(mk(0, B1, 2, 1, 0, 0, 1, 3, 0));
        vt.push_back(mk(0, A2, 3, 0, 0, 1, 1, 3, 0));
        vt.push_back(mk(0, OF, 0, 0, 0, 0, 1, 3, 0));

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].p);
            chk($sformatf("tbl%0d_dir", i), 0, 32'(dir0), 32'(vt[i].d));
            chk($sformatf("tbl%0d_phase", i), 0, 32'(ph0), 32'(vt[i].ph));
            chk($sformatf("tbl%0d_seq_done", i), 0, 32'(sd0), 32'(vt[i].sd));
            chk($sformatf("tbl%0d_err", i), 0, 32'(er0), 32'(vt[i].er));
            chk($sformatf("tbl%0d_err_sticky", i), 0, 32'(st0), 32'(vt[i].st));
            chk($sformatf("tbl%0d_left_count", i), 0, 32'(lc0), 32'(vt[i].lc));
            chk($sformatf("tbl%0d_right_count", i), 0, 32'(rc0), 32'(vt[i].rc));
        end

        step(1, OF);
        step(0, HZP);
`ifdef TBIRD_HAZARD_EN
        chk("hz_dir", 0, 32'(dir0), 3);
        chk("hz_phase", 0, 32'(ph0), 3);
        chk("hz_err", 0, 32'(er0), 0);
        step(0, OF);
        chk("hz_done", 0, 32'(sd0), 1);
        chk("hz_count", 0, 32'(hz0), 1);
`else
        chk("hz_err", 0, 32'(er0), 1);
        chk("hz_dir", 0, 32'(dir0), 3);
        step(0, OF);
        chk("hz_off_dir", 0, 32'(dir0), 0);
`endif

        step(1, OF);
        step(0, A1); step(0, A1); step(0, A2); step(0, A2); step(0, A3); step(0, A3);
        chk("hold2_noerr", 1, 32'(st1), 0);
        step(0, OF);
        chk("hold2_done", 1, 32'(sd1), 1);
        chk("hold2_count", 1, 32'(lc1), 1);
        step(0, A1); step(0, A1);
        chk("hold2_ok", 1, 32'(er1), 0);
        step(0, A1);
        chk("hold2_over", 1, 32'(er1), 1);

        step(1, OF);
        for (int i = 0; i < 5; i++) left_seq();
        chk("sat_cnt2", 2, 32'(lc2), 3);
        chk("cnt8_five", 0, 32'(lc0), 5);

        for (int i = 0; i < 800; i++) begin
            int sel;
            logic [5:0] p;
            sel = $urandom_range(0, 99);
            p = OF;
            if (sel < 2) begin
                step(1, OF);
                continue;
            end else if (sel < 65) begin
                if (m_uns[0] || m_n[0] == 3) p = OF;
                else if (m_side[0] == 0) p = $urandom_range(0, 9) == 0 ? HZP : ($urandom_range(0, 1) ? A1 : B1);
                else p = encode(m_side[0], m_n[0] + 1);
            end else if (sel < 80) p = m_uns[0] ? OF : encode(m_side[0], m_n[0]);
            else p = 6'($urandom);
            step(0, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
